// File: rtl/butterfly_pkg.sv
`default_nettype none
// ============================================================================
// Module      : butterfly_pkg
// Description : Shared constants, packed complex type and the 16-bit
//               saturation helper for the radix-2 butterfly datapath.
//               Components are signed two's complement with FRAC_BITS
//               fractional bits (1.0 = 16'h0040).
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package butterfly_pkg;

    localparam int WORD_SZ   = 32;
    localparam int WORD_MID  = WORD_SZ / 2;
    localparam int FRAC_BITS = 6;

    // One signed 16x16 partial product.
    localparam int PROD_W = 2 * WORD_MID;
    // Sum/difference of two partial products; holds 2^31 from 8000h*8000h*2.
    localparam int CSUM_W = PROD_W + 1;
    // Shifted complex product plus sign-extended A component, never overflows.
    localparam int ACC_W  = CSUM_W + 1;

    localparam logic signed [WORD_MID-1:0] c_sat_max = 16'sh7FFF;
    localparam logic signed [WORD_MID-1:0] c_sat_min = 16'sh8000;

    typedef struct packed {
        logic signed [WORD_MID-1:0] re;
        logic signed [WORD_MID-1:0] im;
    } cplx_t;

    // Clamp a wide signed value into the signed 16-bit output range.
    function automatic logic signed [WORD_MID-1:0] sat16(
        input logic signed [ACC_W-1:0] x
    );
        logic signed [WORD_MID-1:0] result;
        if (x > ACC_W'(c_sat_max)) begin
            result = c_sat_max;
        end else if (x < ACC_W'(c_sat_min)) begin
            result = c_sat_min;
        end else begin
            result = x[WORD_MID-1:0];
        end
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cplx_mult_q.sv
`default_nettype none
// ============================================================================
// Module      : cplx_mult_q
// Description : Complex fixed-point multiply B*W. The four signed partial
//               products are registered (pipeline stage 1); the real/imag
//               combination and the arithmetic right shift by FRAC_BITS are
//               combinational so the parent can add and register in stage 2.
// Ports       : i_clk    - clock, rising edge
//               i_rst_n  - asynchronous active-low reset
//               i_en     - load enable for the product registers
//               i_b      - complex operand B
//               i_w      - complex twiddle W
//               o_re     - (Br*Wr - Bi*Wi) >>> FRAC_BITS
//               o_im     - (Br*Wi + Bi*Wr) >>> FRAC_BITS
// Revision    : 1.0 - initial release
// ============================================================================
module cplx_mult_q
    import butterfly_pkg::*;
(
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_en,
    input  cplx_t                    i_b,
    input  cplx_t                    i_w,
    output logic signed [CSUM_W-1:0] o_re,
    output logic signed [CSUM_W-1:0] o_im
);

    logic signed [PROD_W-1:0] w_rr;
    logic signed [PROD_W-1:0] w_ii;
    logic signed [PROD_W-1:0] w_ri;
    logic signed [PROD_W-1:0] w_ir;

    logic signed [PROD_W-1:0] r_rr;
    logic signed [PROD_W-1:0] r_ii;
    logic signed [PROD_W-1:0] r_ri;
    logic signed [PROD_W-1:0] r_ir;

    logic signed [CSUM_W-1:0] w_re_full;
    logic signed [CSUM_W-1:0] w_im_full;

    assign w_rr = PROD_W'(i_b.re) * PROD_W'(i_w.re);
    assign w_ii = PROD_W'(i_b.im) * PROD_W'(i_w.im);
    assign w_ri = PROD_W'(i_b.re) * PROD_W'(i_w.im);
    assign w_ir = PROD_W'(i_b.im) * PROD_W'(i_w.re);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rr <= '0;
            r_ii <= '0;
            r_ri <= '0;
            r_ir <= '0;
        end else if (i_en) begin
            r_rr <= w_rr;
            r_ii <= w_ii;
            r_ri <= w_ri;
            r_ir <= w_ir;
        end
    end

    // Combine at 33 bits so 8000h*8000h terms cannot overflow, then floor
    // by the fractional weight (arithmetic shift, no rounding).
    assign w_re_full = CSUM_W'(r_rr) - CSUM_W'(r_ii);
    assign w_im_full = CSUM_W'(r_ri) + CSUM_W'(r_ir);

    assign o_re = w_re_full >>> FRAC_BITS;
    assign o_im = w_im_full >>> FRAC_BITS;

endmodule
`default_nettype wire

// File: rtl/butterfly_sum.sv
`default_nettype none
// ============================================================================
// Module      : butterfly_sum
// Description : Radix-2 FFT butterfly, o_A = A + WA*B, o_B = A + WB*B, on
//               packed {re, im} fixed-point words. Two pipeline stages,
//               one sample per clock, no backpressure. Each output
//               component saturates independently to signed 16 bits.
// Ports       : i_clk        - clock, rising edge
//               i_rst_n      - asynchronous active-low reset
//               i_valid      - operands valid this cycle
//               i_A, i_B     - complex operands {re, im}
//               i_twiddleA   - twiddle applied to B for o_A
//               i_twiddleB   - twiddle applied to B for o_B
//               o_valid      - o_A/o_B carry a fresh result this cycle
//               o_A, o_B     - saturated butterfly results {re, im}
// Revision    : 1.0 - initial release
// ============================================================================
module butterfly_sum
    import butterfly_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_valid,
    input  logic [WORD_SZ-1:0] i_A,
    input  logic [WORD_SZ-1:0] i_B,
    input  logic [WORD_SZ-1:0] i_twiddleA,
    input  logic [WORD_SZ-1:0] i_twiddleB,
    output logic               o_valid,
    output logic [WORD_SZ-1:0] o_A,
    output logic [WORD_SZ-1:0] o_B
);

    cplx_t w_a_in;
    cplx_t w_b_in;
    cplx_t w_wa_in;
    cplx_t w_wb_in;

    assign w_a_in  = i_A;
    assign w_b_in  = i_B;
    assign w_wa_in = i_twiddleA;
    assign w_wb_in = i_twiddleB;

    // Stage 1: A and valid travel alongside the product registers.
    cplx_t r_a1;
    logic  r_valid1;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_a1     <= '0;
            r_valid1 <= 1'b0;
        end else begin
            r_valid1 <= i_valid;
            if (i_valid) begin
                r_a1 <= w_a_in;
            end
        end
    end

    logic signed [CSUM_W-1:0] w_pa_re;
    logic signed [CSUM_W-1:0] w_pa_im;
    logic signed [CSUM_W-1:0] w_pb_re;
    logic signed [CSUM_W-1:0] w_pb_im;

    cplx_mult_q u_mult_a (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_en    (i_valid),
        .i_b     (w_b_in),
        .i_w     (w_wa_in),
        .o_re    (w_pa_re),
        .o_im    (w_pa_im)
    );

    cplx_mult_q u_mult_b (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_en    (i_valid),
        .i_b     (w_b_in),
        .i_w     (w_wb_in),
        .o_re    (w_pb_re),
        .o_im    (w_pb_im)
    );

    // Stage 2: full-width add of the sign-extended A component, then clamp.
    logic signed [ACC_W-1:0] w_sum_a_re;
    logic signed [ACC_W-1:0] w_sum_a_im;
    logic signed [ACC_W-1:0] w_sum_b_re;
    logic signed [ACC_W-1:0] w_sum_b_im;
    cplx_t                   w_res_a;
    cplx_t                   w_res_b;

    assign w_sum_a_re = ACC_W'(w_pa_re) + ACC_W'(r_a1.re);
    assign w_sum_a_im = ACC_W'(w_pa_im) + ACC_W'(r_a1.im);
    assign w_sum_b_re = ACC_W'(w_pb_re) + ACC_W'(r_a1.re);
    assign w_sum_b_im = ACC_W'(w_pb_im) + ACC_W'(r_a1.im);

    assign w_res_a.re = sat16(w_sum_a_re);
    assign w_res_a.im = sat16(w_sum_a_im);
    assign w_res_b.re = sat16(w_sum_b_re);
    assign w_res_b.im = sat16(w_sum_b_im);

    cplx_t r_out_a;
    cplx_t r_out_b;
    logic  r_valid2;

    // Outputs only update on a valid sample, otherwise hold the last result.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_out_a  <= '0;
            r_out_b  <= '0;
            r_valid2 <= 1'b0;
        end else begin
            r_valid2 <= r_valid1;
            if (r_valid1) begin
                r_out_a <= w_res_a;
                r_out_b <= w_res_b;
            end
        end
    end

    assign o_valid = r_valid2;
    assign o_A     = r_out_a;
    assign o_B     = r_out_b;

endmodule
`default_nettype wire

// File: tb/tb_butterfly_sum.sv
`default_nettype none
// ============================================================================
// Module      : tb_butterfly_sum
// Description : Self-checking bench for butterfly_sum. Directed vector table
//               with hand-computed results, back-to-back random stream
//               against an independent saturating model, and an
//               asynchronous reset applied with samples in flight.
// Ports       : none
// Revision    : 1.0 - initial release
// ============================================================================
module tb_butterfly_sum;

    logic        clk;
    logic        rst_n;
    logic        valid;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] wa;
    logic [31:0] wb;
    logic        out_valid;
    logic [31:0] out_a;
    logic [31:0] out_b;

    int errors = 0;
    int checks = 0;

    butterfly_sum dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_valid    (valid),
        .i_A        (a),
        .i_B        (b),
        .i_twiddleA (wa),
        .i_twiddleB (wb),
        .o_valid    (out_valid),
        .o_A        (out_a),
        .o_B        (out_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] wa;
        logic [31:0] wb;
        logic [31:0] ea;
        logic [31:0] eb;
    } vec_t;

    vec_t vecs [7];

    logic [31:0] s_a  [8];
    logic [31:0] s_b  [8];
    logic [31:0] s_wa [8];
    logic [31:0] s_wb [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] ref_sat(input longint v);
        if (v > 32767)       return 16'h7FFF;
        else if (v < -32768) return 16'h8000;
        else                 return v[15:0];
    endfunction

    // Reference: A + W*B with floor division by 64 and per-component clamp.
    function automatic logic [31:0] ref_bfly(input logic [31:0] av,
                                             input logic [31:0] bv,
                                             input logic [31:0] wv);
        longint ar, ai, br, bi, wr, wi, pr, pi;
        ar = longint'($signed(av[31:16]));
        ai = longint'($signed(av[15:0]));
        br = longint'($signed(bv[31:16]));
        bi = longint'($signed(bv[15:0]));
        wr = longint'($signed(wv[31:16]));
        wi = longint'($signed(wv[15:0]));
        pr = (br * wr - bi * wi) >>> 6;
        pi = (br * wi + bi * wr) >>> 6;
        return {ref_sat(ar + pr), ref_sat(ai + pi)};
    endfunction

    initial begin
        //               A             B             WA            WB            exp o_A       exp o_B
        vecs[0] = '{32'h0040_0080, 32'h00C0_0100, 32'h0040_0000, 32'hFFC0_0000, 32'h0100_0180, 32'hFF80_FF80};
        vecs[1] = '{32'h0000_0000, 32'h0040_0000, 32'h0000_0040, 32'h0000_FFC0, 32'h0000_0040, 32'h0000_FFC0};
        vecs[2] = '{32'h7FC0_8000, 32'h0040_0040, 32'h0040_0000, 32'hFFC0_0000, 32'h7FFF_8040, 32'h7F80_8000};
        vecs[3] = '{32'h0000_0000, 32'h0001_0000, 32'h0020_0000, 32'hFFE0_0000, 32'h0000_0000, 32'hFFFF_0000};
        vecs[4] = '{32'h0000_0000, 32'h8000_8000, 32'h8000_8000, 32'h0000_8000, 32'h0000_7FFF, 32'h8000_7FFF};
        vecs[5] = '{32'h0001_FFFF, 32'h0100_0080, 32'h0020_0030, 32'hFFE0_FFD0, 32'h0021_00FF, 32'hFFE1_FEFF};
        vecs[6] = '{32'h0010_0020, 32'h00C0_FEC0, 32'h0040_0000, 32'hFFC0_0000, 32'h00D0_FEE0, 32'hFF50_0160};

        // Reset held with live inputs: outputs must stay cleared.
        rst_n = 1'b0;
        valid = 1'b1;
        a  = vecs[0].a;
        b  = vecs[0].b;
        wa = vecs[0].wa;
        wb = vecs[0].wb;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset o_valid", {31'b0, out_valid}, 32'h0);
        check("reset o_A", out_a, 32'h0);
        check("reset o_B", out_b, 32'h0);
        valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("post-release o_valid", {31'b0, out_valid}, 32'h0);
        check("post-release o_A", out_a, 32'h0);

        // Directed table: isolated pulses, latency, one-cycle valid, hold.
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            a  = vecs[i].a;
            b  = vecs[i].b;
            wa = vecs[i].wa;
            wb = vecs[i].wb;
            valid = 1'b1;
            @(negedge clk);
            valid = 1'b0;
            a  = ~vecs[i].a;
            b  = ~vecs[i].b;
            wa = ~vecs[i].wa;
            wb = ~vecs[i].wb;
            check($sformatf("vec%0d o_valid early", i), {31'b0, out_valid}, 32'h0);
            @(negedge clk);
            check($sformatf("vec%0d o_valid", i), {31'b0, out_valid}, 32'h1);
            check($sformatf("vec%0d o_A", i), out_a, vecs[i].ea);
            check($sformatf("vec%0d o_B", i), out_b, vecs[i].eb);
            @(negedge clk);
            check($sformatf("vec%0d o_valid drop", i), {31'b0, out_valid}, 32'h0);
            check($sformatf("vec%0d o_A hold", i), out_a, vecs[i].ea);
        end

        // Back-to-back random stream.
        for (int i = 0; i < 8; i++) begin
            s_a[i]  = $urandom;
            s_b[i]  = $urandom;
            s_wa[i] = (i < 4) ? $urandom : {16'($urandom_range(0, 255)) - 16'd128,
                                            16'($urandom_range(0, 255)) - 16'd128};
            s_wb[i] = $urandom;
        end
        for (int k = 0; k <= 10; k++) begin
            @(negedge clk);
            if (k >= 2 && k < 10) begin
                check($sformatf("stream%0d o_valid", k - 2), {31'b0, out_valid}, 32'h1);
                check($sformatf("stream%0d o_A", k - 2), out_a, ref_bfly(s_a[k-2], s_b[k-2], s_wa[k-2]));
                check($sformatf("stream%0d o_B", k - 2), out_b, ref_bfly(s_a[k-2], s_b[k-2], s_wb[k-2]));
            end
            if (k == 10) begin
                check("stream end o_valid", {31'b0, out_valid}, 32'h0);
            end
            if (k < 8) begin
                a  = s_a[k];
                b  = s_b[k];
                wa = s_wa[k];
                wb = s_wb[k];
                valid = 1'b1;
            end else begin
                valid = 1'b0;
            end
        end

        // Asynchronous reset with one result on the outputs and one in stage 1.
        @(negedge clk);
        a  = vecs[0].a;
        b  = vecs[0].b;
        wa = vecs[0].wa;
        wb = vecs[0].wb;
        valid = 1'b1;
        @(negedge clk);
        a  = vecs[5].a;
        b  = vecs[5].b;
        wa = vecs[5].wa;
        wb = vecs[5].wb;
        @(negedge clk);
        valid = 1'b0;
        check("pre-reset o_valid", {31'b0, out_valid}, 32'h1);
        check("pre-reset o_A", out_a, vecs[0].ea);
        #1;
        rst_n = 1'b0;
        #1;
        check("async reset o_valid", {31'b0, out_valid}, 32'h0);
        check("async reset o_A", out_a, 32'h0);
        check("async reset o_B", out_b, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("after reset%0d o_valid", k), {31'b0, out_valid}, 32'h0);
            check($sformatf("after reset%0d o_A", k), out_a, 32'h0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
